// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor with a valid/ready handshake on both sides.
// Each stage resolves BLKS_PER_STG blocks; upper operand bits ride along until their stage.
module csel_adder_pipe #(
  parameter int WIDTH        = 16,
  parameter int BLK          = 4,
  parameter int BLKS_PER_STG = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLK;
  localparam int NSTG = WIDTH / (BLK * BLKS_PER_STG);

  // Resolves the blocks owned by stage stg; returns {ovf, carry_out, partial_sum}.
  function automatic logic [WIDTH+1:0] f_resolve(
    input logic [WIDTH-1:0] fa,
    input logic [WIDTH-1:0] fb,
    input logic [WIDTH-1:0] fs,
    input logic             fc,
    input int               stg
  );
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ov;
    logic [BLK:0]     s0;
    logic [BLK:0]     s1;
    logic [BLK:0]     t;
    s  = fs;
    c  = fc;
    ov = 1'b0;
    for (int j = 0; j < NBLK; j++) begin
      if (j / BLKS_PER_STG == stg) begin
        s0 = {1'b0, fa[j*BLK +: BLK]} + {1'b0, fb[j*BLK +: BLK]};
        s1 = s0 + (BLK+1)'(1);
        if (j == 0)
          t = s0 + {{BLK{1'b0}}, c};
        else
          t = c ? s1 : s0;
        s[j*BLK +: BLK] = t[BLK-1:0];
        if (j == NBLK-1)
          ov = t[BLK] ^ (t[BLK-1] ^ fa[WIDTH-1] ^ fb[WIDTH-1]);
        c = t[BLK];
      end
    end
    return {ov, c, s};
  endfunction

  logic             r_init;
  logic [NSTG-1:0]  r_vld;
  logic [NSTG-1:0]  w_ld;
  logic [WIDTH-1:0] r_a_p   [NSTG];
  logic [WIDTH-1:0] r_b_p   [NSTG];
  logic [WIDTH-1:0] r_sum_p [NSTG];
  logic             r_c_p   [NSTG];
  logic             r_ov_p  [NSTG];
  logic             w_xfer;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  assign w_b_eff   = sub ? ~b : b;
  assign w_cin_eff = sub | cin;
  assign w_xfer    = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_init <= 1'b0;
    else        r_init <= 1'b1;
  end

  // Load enables ripple back from the output so bubbles collapse without ready registers.
  always_comb begin
    w_ld = '0;
    w_ld[NSTG-1] = ~r_vld[NSTG-1] | out_ready;
    for (int k = NSTG-2; k >= 0; k--)
      w_ld[k] = ~r_vld[k] | w_ld[k+1];
  end

  assign in_ready = r_init & w_ld[0];

  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    logic [WIDTH+1:0] w_res;
    logic             w_vin;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;

    if (k == 0) begin : g_first
      assign w_vin  = w_xfer;
      assign w_a_in = a;
      assign w_b_in = w_b_eff;
      assign w_res  = f_resolve(a, w_b_eff, '0, w_cin_eff, 0);
    end else begin : g_next
      assign w_vin  = r_vld[k-1];
      assign w_a_in = r_a_p[k-1];
      assign w_b_in = r_b_p[k-1];
      assign w_res  = f_resolve(r_a_p[k-1], r_b_p[k-1], r_sum_p[k-1], r_c_p[k-1], k);
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld[k]   <= 1'b0;
        r_sum_p[k] <= '0;
        r_c_p[k]   <= 1'b0;
        r_ov_p[k]  <= 1'b0;
      end else if (w_ld[k]) begin
        r_vld[k] <= w_vin;
        if (w_vin) begin
          r_sum_p[k] <= w_res[WIDTH-1:0];
          r_c_p[k]   <= w_res[WIDTH];
          r_ov_p[k]  <= w_res[WIDTH+1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (w_ld[k] & w_vin) begin
        r_a_p[k] <= w_a_in;
        r_b_p[k] <= w_b_in;
      end
    end
  end

  assign out_valid = r_vld[NSTG-1];
  assign sum       = r_sum_p[NSTG-1];
  assign cout      = r_c_p[NSTG-1];
  assign ovf       = r_ov_p[NSTG-1];

endmodule
